// File: rtl/dm_pkg.sv
// Shared DataMemory definitions: DMCtrl codes, initiator FSM states and the
// load-extension helper used by both the initiator and the core writeback mux.
// Combinational helpers only; no state, no ports.
package dm_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} lsu_state_t;

  // Sign- or zero-extend a right-aligned raw value according to the DMCtrl code.
  function automatic logic [31:0] dm_extend(input logic [2:0] ctrl, input logic [31:0] raw);
    logic [31:0] ext;
    ext = raw;
    case (ctrl)
      DM_B:    ext = {{24{raw[7]}}, raw[7:0]};
      DM_H:    ext = {{16{raw[15]}}, raw[15:0]};
      DM_BU:   ext = {24'h0, raw[7:0]};
      DM_HU:   ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one core request in, DataMemory accesses out, one response back.
// Latency from accept edge: error 1 cycle, aligned 2, misaligned split k+1 (k=2 half, 4 word).
// Backpressure: req_ready only in IDLE; response held in RESP until resp_ready.
// Ports: clk/rst_n (sync, active-low); req_* core request (valid/ready);
//   resp_* core response (valid/ready); Address/DataWr/DMWr/DMCtrl/DataRd DataMemory port.
module lsu_mem_initiator
  import dm_pkg::*;
#(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter logic [31:0] ADDR_LIMIT       = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctrl,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] DataWr,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  input  logic [31:0] DataRd
);

  lsu_state_t  state, state_nxt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_ctrl;
  logic [1:0]  cnt;
  logic [31:0] acc;

  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic        req_illegal, req_oob, req_mis, req_err;
  logic        last_beat;
  logic [4:0]  beat_sh;
  logic [31:0] acc_nxt;
  logic [31:0] wdata_sh;
  logic        dm_wr;

  // Accept-time checks on the live request. The end address is formed in 33 bits
  // so an access that wraps past 2^32 lands above ADDR_LIMIT and is rejected.
  always_comb begin
    case (req_ctrl[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    req_illegal = (req_ctrl == 3'b011) || (req_ctrl == 3'b110) || (req_ctrl == 3'b111);
    req_end     = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;
    req_oob     = (req_end >= {1'b0, ADDR_LIMIT});
    req_mis     = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err     = req_illegal || req_oob || (req_mis && !ALLOW_MISALIGNED);
  end

  // Split beats walk bytes LSB first; the beat index doubles as a byte shift.
  assign last_beat = (cnt == (r_ctrl[1] ? 2'd3 : 2'd1));
  assign beat_sh   = {cnt, 3'b000};
  assign acc_nxt   = acc | ({24'h0, DataRd[7:0]} << beat_sh);
  assign wdata_sh  = r_wdata >> beat_sh;

  assign req_ready  = (state == IDLE) && rst_n;
  assign resp_valid = (state == RESP);
  // Gate the write strobe with reset so a reset edge can never commit a beat.
  assign DMWr       = dm_wr && rst_n;

  always_comb begin
    state_nxt = state;
    Address   = 32'h0;
    DataWr    = 32'h0;
    dm_wr     = 1'b0;
    DMCtrl    = DM_W;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)      state_nxt = RESP;
          else if (req_mis) state_nxt = SPLIT;
          else              state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        Address   = r_addr;
        DMCtrl    = r_ctrl;
        DataWr    = r_wdata;
        dm_wr     = r_we;
        state_nxt = RESP;
      end
      SPLIT: begin
        Address = r_addr + {30'b0, cnt};
        DMCtrl  = r_we ? DM_B : DM_BU;
        DataWr  = r_we ? {24'h0, wdata_sh[7:0]} : 32'h0;
        dm_wr   = r_we;
        if (last_beat) state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_ctrl     <= 3'b000;
      cnt        <= 2'd0;
      acc        <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // rst_n is high in this branch, so req_ready is implied by IDLE.
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_ctrl     <= req_ctrl;
            cnt        <= 2'd0;
            acc        <= 32'h0;
            resp_err   <= req_err;
            resp_rdata <= 32'h0;
          end
        end
        ACCESS: begin
          if (!r_we) resp_rdata <= DataRd;
        end
        SPLIT: begin
          cnt <= cnt + 2'd1;
          acc <= acc_nxt;
          if (last_beat && !r_we) resp_rdata <= dm_extend(r_ctrl, acc_nxt);
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench: two initiators (misaligned split enabled / rejected), each
// driving its own byte-array DataMemory responder, checked against a byte-level model.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_ctrl   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [31:0] Address    [2];
  logic [31:0] DataWr     [2];
  logic        DMWr       [2];
  logic [2:0]  DMCtrl     [2];
  logic [31:0] DataRd     [2];

  logic [7:0]  mem     [2][1024] = '{default: 8'h00};
  logic [7:0]  ref_mem [2][1024];
  int          wr_cnt  [2] = '{0, 0};
  logic [63:0] wlog [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b1), .ADDR_LIMIT(32'h0000_1000)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ctrl(req_ctrl[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .Address(Address[0]), .DataWr(DataWr[0]), .DMWr(DMWr[0]), .DMCtrl(DMCtrl[0]),
    .DataRd(DataRd[0])
  );

  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b0), .ADDR_LIMIT(32'h0000_1000)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ctrl(req_ctrl[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .Address(Address[1]), .DataWr(DataWr[1]), .DMWr(DMWr[1]), .DMCtrl(DMCtrl[1]),
    .DataRd(DataRd[1])
  );

  // DataMemory responder: little-endian bytes, 10-bit address, combinational read.
  function automatic logic [31:0] mem_rd(input logic [31:0] w, input logic [2:0] c);
    case (c)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++)
      DataRd[i] = mem_rd({mem[i][Address[i][9:0] + 10'd3], mem[i][Address[i][9:0] + 10'd2],
                          mem[i][Address[i][9:0] + 10'd1], mem[i][Address[i][9:0]]}, DMCtrl[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (DMWr[i]) begin
        wr_cnt[i] <= wr_cnt[i] + 1;
        mem[i][Address[i][9:0]] <= DataWr[i][7:0];
        if (DMCtrl[i][1:0] != 2'b00) mem[i][Address[i][9:0] + 10'd1] <= DataWr[i][15:8];
        if (DMCtrl[i][1]) begin
          mem[i][Address[i][9:0] + 10'd2] <= DataWr[i][23:16];
          mem[i][Address[i][9:0] + 10'd3] <= DataWr[i][31:24];
        end
        if (i == 0) wlog.push_back({Address[0], DataWr[0]});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance d, with expectations from the byte model.
  task automatic xact(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] ctrl,
                      input int hold, output logic [31:0] rdata);
    int          size, e_lat, e_nwr, lat, wr0;
    bit          illegal, mis, e_err;
    logic [31:0] e_rd, mask;
    logic [63:0] end_excl;
    size     = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
    illegal  = (ctrl == 3'd3) || (ctrl == 3'd6) || (ctrl == 3'd7);
    mis      = (addr % size) != 0;
    end_excl = {32'h0, addr} + 64'(size);
    e_err    = illegal || (end_excl > 64'h1000) || (mis && d == 1);
    e_lat    = e_err ? 1 : (mis ? size + 1 : 2);
    e_nwr    = (e_err || we) ? ((e_err) ? 0 : (mis ? size : 1)) : 0;
    e_rd     = 32'h0;
    if (!e_err && !we) begin
      for (int j = 0; j < size; j++)
        e_rd = e_rd | (32'(ref_mem[d][(addr + j) & 32'h3FF]) << (8 * j));
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        if (!ctrl[2] && e_rd[8 * size - 1]) e_rd = e_rd | ~mask;
      end
    end

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_ctrl[d]  = ctrl;
    wr0          = wr_cnt[d];
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b0;
    req_addr[d]  = 32'h0;
    req_wdata[d] = 32'h0;
    req_ctrl[d]  = 3'b000;
    lat = 1;
    while (!resp_valid[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_rdata", resp_rdata[d], e_rd);
    chk("resp_err", 32'(resp_err[d]), 32'(e_err));
    chk("dmwr_beats", 32'(wr_cnt[d] - wr0), 32'(e_nwr));
    rdata = resp_rdata[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], e_rd);
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("resp_valid_drop", 32'(resp_valid[d]), 32'd0);
    chk("req_ready_back", 32'(req_ready[d]), 32'd1);
    if (we && !e_err)
      for (int j = 0; j < size; j++)
        ref_mem[d][(addr + j) & 32'h3FF] = 8'(wdata >> (8 * j));
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  ctrls [8];
    ctrls = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3};
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 1024; a++) ref_mem[d][a] = 8'h00;
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_ctrl[d] = 3'b000; resp_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_resp_rdata", resp_rdata[0], 32'h0);
    chk("rst_resp_err", 32'(resp_err[0]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_address", Address[0], 32'h0);
    chk("rst_dmctrl", 32'(DMCtrl[0]), 32'h2);
    chk("rst_dmwr", 32'(DMWr[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready[0]), 32'd1);

    // 1: aligned word store / load
    xact(0, 1'b1, 32'h20, 32'h1234_5678, 3'b010, 0, rd);
    xact(0, 1'b0, 32'h20, 32'h0, 3'b010, 0, rd);
    chk("t1_lw20", rd, 32'h1234_5678);

    // 2: misaligned word store split into byte beats
    xact(0, 1'b1, 32'h30, 32'h0, 3'b010, 0, rd);
    wlog.delete();
    xact(0, 1'b1, 32'h31, 32'hA3A2_A1A0, 3'b010, 0, rd);
    chk("t2_beats", 32'(wlog.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < wlog.size()) begin
        chk("t2_beat_addr", wlog[j][63:32], 32'h31 + 32'(j));
        chk("t2_beat_data", wlog[j][31:0], 32'hA0 + 32'(j));
      end
    end
    xact(0, 1'b0, 32'h30, 32'h0, 3'b010, 0, rd);
    chk("t2_lw30", rd, 32'hA2A1_A000);
    xact(0, 1'b0, 32'h34, 32'h0, 3'b010, 0, rd);
    chk("t2_lw34", rd, 32'h0000_00A3);
    xact(0, 1'b0, 32'h31, 32'h0, 3'b010, 0, rd);
    chk("t2_lw31", rd, 32'hA3A2_A1A0);

    // 3: misaligned halves and extension
    xact(0, 1'b0, 32'h33, 32'h0, 3'b001, 0, rd);
    chk("t3_lh33", rd, 32'hFFFF_A3A2);
    xact(0, 1'b0, 32'h33, 32'h0, 3'b101, 0, rd);
    chk("t3_lhu33", rd, 32'h0000_A3A2);
    xact(0, 1'b0, 32'h32, 32'h0, 3'b000, 0, rd);
    chk("t3_lb32", rd, 32'hFFFF_FFA1);

    // 4: rejection paths on the non-splitting instance, plus range boundaries
    xact(1, 1'b0, 32'h02, 32'h0, 3'b010, 0, rd);
    xact(1, 1'b1, 32'h02, 32'h5555_5555, 3'b010, 0, rd);
    xact(1, 1'b0, 32'h10, 32'h0, 3'b011, 0, rd);
    xact(1, 1'b0, 32'hFFFF_FFFE, 32'h0, 3'b010, 0, rd);
    xact(1, 1'b1, 32'h0000_0FFF, 32'h0000_005A, 3'b000, 0, rd);
    xact(1, 1'b0, 32'h0000_0FFF, 32'h0, 3'b100, 0, rd);
    chk("t4_lbu_fff", rd, 32'h0000_005A);
    xact(1, 1'b1, 32'h0000_1000, 32'h0000_00EE, 3'b000, 0, rd);
    xact(0, 1'b0, 32'h0000_0FFF, 32'h0, 3'b001, 0, rd);
    xact(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 3'b010, 0, rd);

    // 5: reset in the middle of a split store
    xact(0, 1'b1, 32'h40, 32'h0, 3'b010, 0, rd);
    xact(0, 1'b1, 32'h44, 32'h0, 3'b010, 0, rd);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h41;
    req_wdata[0] = 32'h4433_2211; req_ctrl[0] = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0; req_we[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_dmwr_in_reset", 32'(DMWr[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_req_ready_first", 32'(req_ready[0]), 32'd1);
    chk("t5_resp_valid", 32'(resp_valid[0]), 32'd0);
    ref_mem[0][32'h41] = 8'h11;
    ref_mem[0][32'h42] = 8'h22;
    xact(0, 1'b0, 32'h40, 32'h0, 3'b010, 0, rd);
    chk("t5_lw40", rd, 32'h0022_1100);
    xact(0, 1'b0, 32'h44, 32'h0, 3'b010, 0, rd);
    chk("t5_lw44", rd, 32'h0);

    // 6: response backpressure
    xact(0, 1'b0, 32'h31, 32'h0, 3'b010, 3, rd);
    chk("t6_lw31_held", rd, 32'hA3A2_A1A0);

    // Randomized traffic against the byte model
    for (int n = 0; n < 80; n++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 9) == 0) ra = 32'hFF8 + $urandom_range(0, 15);
      else                            ra = 32'h100 + $urandom_range(0, 31);
      xact(0, 1'($urandom_range(0, 1)), ra, $urandom, ctrls[$urandom_range(0, 7)],
           $urandom_range(0, 2), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
